// File: rtl/mem_access_stage.sv
// Pipeline memory-access stage: passes ALU results through or performs one data-memory access with timeout.
// Optional MEM_ALIGN_CHECK_EN macro enables misaligned half/word detection (align_exc).
module mem_access_stage #(
  parameter int REG_ADDR_W  = 5,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [REG_ADDR_W-1:0] ex_wd,
  input  logic                  ex_wreg,
  input  logic [31:0]           ex_wdata,
  input  logic [3:0]            ex_memop,
  input  logic [31:0]           ex_sdata,
  output logic                  dm_req,
  output logic                  dm_we,
  output logic [31:0]           dm_addr,
  output logic [3:0]            dm_sel,
  output logic [31:0]           dm_wdata,
  input  logic                  dm_ack,
  input  logic [31:0]           dm_rdata,
  output logic                  wb_valid,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [31:0]           wdata_o,
  output logic                  stall_req,
  output logic                  bus_err,
  output logic                  align_exc
);

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  localparam logic [3:0] OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3, OP_LHU = 4'd4,
                         OP_LW = 4'd5, OP_SB  = 4'd6, OP_SH = 4'd7, OP_SW  = 4'd8;
  localparam logic [7:0] LP_LAST_CNT = 8'(ACK_TIMEOUT - 1);

  state_t                r_state, w_next;
  logic [7:0]            r_cnt;
  logic [3:0]            r_memop;
  logic [1:0]            r_a;
  logic [REG_ADDR_W-1:0] r_cap_wd;
  logic                  r_cap_wreg;
  logic [31:0]           r_cap_wdata;

  logic                  r_dm_req, r_dm_we, r_wb_valid, r_wreg, r_bus_err;
  logic [31:0]           r_dm_addr, r_dm_wdata, r_wdata;
  logic [3:0]            r_dm_sel;
  logic [REG_ADDR_W-1:0] r_wd;

  logic [1:0]  w_a;
  logic        w_is_load, w_is_store, w_is_byte, w_is_half, w_is_word, w_misaligned;
  logic        w_start, w_pass, w_ack, w_timeout;
  logic [3:0]  w_sel;
  logic [31:0] w_sdata, w_ldata;
  logic [7:0]  w_rbyte;
  logic [15:0] w_rhalf;

  assign w_a        = ex_wdata[1:0];
  assign w_is_load  = (ex_memop >= OP_LB) && (ex_memop <= OP_LW);
  assign w_is_store = (ex_memop >= OP_SB) && (ex_memop <= OP_SW);
  assign w_is_byte  = (ex_memop == OP_LB) || (ex_memop == OP_LBU) || (ex_memop == OP_SB);
  assign w_is_half  = (ex_memop == OP_LH) || (ex_memop == OP_LHU) || (ex_memop == OP_SH);
  assign w_is_word  = (ex_memop == OP_LW) || (ex_memop == OP_SW);

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misaligned = (w_is_half && w_a[0]) || (w_is_word && (w_a != 2'b00));
`else
  assign w_misaligned = 1'b0;
`endif

  assign w_start   = (r_state == S_IDLE) && ex_valid && (w_is_load || w_is_store) && !w_misaligned;
  assign w_pass    = (r_state == S_IDLE) && ex_valid && !w_start;
  assign w_ack     = (r_state == S_ACCESS) && dm_ack;
  assign w_timeout = (r_state == S_ACCESS) && !dm_ack && (r_cnt == LP_LAST_CNT);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_sel   = 4'b1111;
    w_sdata = ex_sdata;
    if (w_is_byte) begin
      w_sel   = 4'b0001 << w_a;
      w_sdata = {4{ex_sdata[7:0]}};
    end else if (w_is_half) begin
      w_sel   = w_a[1] ? 4'b1100 : 4'b0011;
      w_sdata = {2{ex_sdata[15:0]}};
    end
  end

  // Load formatting uses the address bits captured on ACCESS entry.
  assign w_rbyte = dm_rdata[{r_a, 3'b000} +: 8];
  assign w_rhalf = r_a[1] ? dm_rdata[31:16] : dm_rdata[15:0];

  always_comb begin
    w_ldata = dm_rdata;
    case (r_memop)
      OP_LB:   w_ldata = {{24{w_rbyte[7]}}, w_rbyte};
      OP_LBU:  w_ldata = {24'd0, w_rbyte};
      OP_LH:   w_ldata = {{16{w_rhalf[15]}}, w_rhalf};
      OP_LHU:  w_ldata = {16'd0, w_rhalf};
      default: w_ldata = dm_rdata;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_start) w_next = S_ACCESS;
      S_ACCESS: if (w_ack || w_timeout) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt       <= 8'd0;
      r_memop     <= 4'd0;
      r_a         <= 2'd0;
      r_cap_wd    <= '0;
      r_cap_wreg  <= 1'b0;
      r_cap_wdata <= 32'd0;
      r_dm_req    <= 1'b0;
      r_dm_we     <= 1'b0;
      r_dm_addr   <= 32'd0;
      r_dm_sel    <= 4'd0;
      r_dm_wdata  <= 32'd0;
      r_wb_valid  <= 1'b0;
      r_wd        <= '0;
      r_wreg      <= 1'b0;
      r_wdata     <= 32'd0;
      r_bus_err   <= 1'b0;
    end else begin
      r_wb_valid <= 1'b0;
      r_bus_err  <= 1'b0;
      if (w_pass) begin
        r_wb_valid <= 1'b1;
        r_wd       <= ex_wd;
        r_wreg     <= ex_wreg && !w_misaligned;
        r_wdata    <= ex_wdata;
      end
      if (w_start) begin
        r_cnt       <= 8'd0;
        r_memop     <= ex_memop;
        r_a         <= w_a;
        r_cap_wd    <= ex_wd;
        r_cap_wreg  <= ex_wreg;
        r_cap_wdata <= ex_wdata;
        r_dm_req    <= 1'b1;
        r_dm_we     <= w_is_store;
        r_dm_addr   <= {ex_wdata[31:2], 2'b00};
        r_dm_sel    <= w_sel;
        r_dm_wdata  <= w_sdata;
      end else if (r_state == S_ACCESS && !dm_ack) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (w_ack || w_timeout) begin
        r_dm_req   <= 1'b0;
        r_dm_we    <= 1'b0;
        r_wb_valid <= 1'b1;
        r_wd       <= r_cap_wd;
        r_wreg     <= 1'b0;
        r_wdata    <= r_cap_wdata;
        r_bus_err  <= w_timeout;
        if (w_ack && (r_memop <= OP_LW)) begin
          r_wreg  <= r_cap_wreg;
          r_wdata <= w_ldata;
        end
      end
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic r_align_exc;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_align_exc <= 1'b0;
    else      r_align_exc <= w_pass && w_misaligned;
  end
  assign align_exc = r_align_exc;
`else
  assign align_exc = 1'b0;
`endif

  assign ex_ready  = (r_state == S_IDLE);
  assign stall_req = (r_state == S_ACCESS);
  assign dm_req    = r_dm_req;
  assign dm_we     = r_dm_we;
  assign dm_addr   = r_dm_addr;
  assign dm_sel    = r_dm_sel;
  assign dm_wdata  = r_dm_wdata;
  assign wb_valid  = r_wb_valid;
  assign wd_o      = r_wd;
  assign wreg_o    = r_wreg;
  assign wdata_o   = r_wdata;
  assign bus_err   = r_bus_err;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage (default build, alignment check disabled).
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_ready, ex_wreg;
  logic [4:0]  ex_wd, wd_o;
  logic [31:0] ex_wdata, ex_sdata, dm_addr, dm_wdata, dm_rdata, wdata_o;
  logic [3:0]  ex_memop, dm_sel;
  logic        dm_req, dm_we, dm_ack, wb_valid, wreg_o, stall_req, bus_err, align_exc;

  int n_cmp  = 0;
  int n_fail = 0;
  int req_cycles, stall_cycles;
  logic saw_err, wbv_at_err, wreg_at_err;

  always #5 clk = ~clk;

  mem_access_stage #(.REG_ADDR_W(5), .ACK_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_wd(ex_wd), .ex_wreg(ex_wreg),
    .ex_wdata(ex_wdata), .ex_memop(ex_memop), .ex_sdata(ex_sdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_sel(dm_sel),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .wb_valid(wb_valid), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .stall_req(stall_req), .bus_err(bus_err), .align_exc(align_exc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [4:0] wd, input logic wreg,
                       input logic [31:0] addr, input logic [31:0] sdata);
    ex_valid = 1'b1; ex_memop = op; ex_wd = wd; ex_wreg = wreg;
    ex_wdata = addr; ex_sdata = sdata;
    tick();
    ex_valid = 1'b0;
  endtask

  task automatic ack_now(input logic [31:0] rdata);
    dm_ack = 1'b1; dm_rdata = rdata;
    tick();
    dm_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b0; ex_valid = 1'b0; ex_wd = '0; ex_wreg = 1'b0; ex_wdata = '0;
    ex_memop = '0; ex_sdata = '0; dm_ack = 1'b0; dm_rdata = '0;
    tick(); tick();
    check("rst_dm_req",    32'(dm_req),    32'd0);
    check("rst_wb_valid",  32'(wb_valid),  32'd0);
    check("rst_stall",     32'(stall_req), 32'd0);
    check("rst_wdata_o",   wdata_o,        32'd0);
    check("rst_wd_o",      32'(wd_o),      32'd0);
    check("rst_ex_ready",  32'(ex_ready),  32'd1);
    rst = 1'b1;
    tick();

    // Passthrough, then hold between pulses
    issue(4'b0000, 5'd3, 1'b1, 32'h1234_5678, 32'd0);
    check("pass_wb_valid", 32'(wb_valid), 32'd1);
    check("pass_wd_o",     32'(wd_o),     32'd3);
    check("pass_wdata_o",  wdata_o,       32'h1234_5678);
    check("pass_wreg_o",   32'(wreg_o),   32'd1);
    check("pass_dm_req",   32'(dm_req),   32'd0);
    tick();
    check("pass_pulse_end", 32'(wb_valid), 32'd0);
    check("pass_hold",      wdata_o,       32'h1234_5678);

    // Unused memop code behaves as none
    issue(4'b1111, 5'd9, 1'b1, 32'h0000_0ABC, 32'd0);
    check("badop_wb_valid", 32'(wb_valid), 32'd1);
    check("badop_dm_req",   32'(dm_req),   32'd0);
    check("badop_wdata_o",  wdata_o,       32'h0000_0ABC);

    // LB at 0x103, ack in third ACCESS cycle
    issue(4'b0001, 5'd5, 1'b1, 32'h0000_0103, 32'd0);
    check("lb_dm_req",   32'(dm_req),   32'd1);
    check("lb_dm_sel",   32'(dm_sel),   32'b1000);
    check("lb_dm_addr",  dm_addr,       32'h0000_0100);
    check("lb_dm_we",    32'(dm_we),    32'd0);
    check("lb_ex_ready", 32'(ex_ready), 32'd0);
    stall_cycles = 32'(stall_req);
    tick();
    stall_cycles += 32'(stall_req);
    check("lb_addr_stable", dm_addr, 32'h0000_0100);
    tick();
    stall_cycles += 32'(stall_req);
    ack_now(32'h80FF_FFFF);
    stall_cycles += 32'(stall_req);
    check("lb_stall_cycles", 32'(stall_cycles), 32'd3);
    check("lb_wb_valid", 32'(wb_valid), 32'd1);
    check("lb_wdata_o",  wdata_o,       32'hFFFF_FF80);
    check("lb_wreg_o",   32'(wreg_o),   32'd1);
    check("lb_wd_o",     32'(wd_o),     32'd5);
    check("lb_dm_req_dropped", 32'(dm_req), 32'd0);

    // SH at 0x202, then an ack in IDLE must be ignored
    issue(4'b0111, 5'd7, 1'b1, 32'h0000_0202, 32'h0000_BEEF);
    check("sh_dm_we",    32'(dm_we),  32'd1);
    check("sh_dm_sel",   32'(dm_sel), 32'b1100);
    check("sh_dm_wdata", dm_wdata,    32'hBEEF_BEEF);
    check("sh_dm_addr",  dm_addr,     32'h0000_0200);
    dm_ack = 1'b1; dm_rdata = 32'h5555_5555;
    tick();
    check("sh_wb_valid", 32'(wb_valid), 32'd1);
    check("sh_wreg_o",   32'(wreg_o),   32'd0);
    check("sh_wdata_o",  wdata_o,       32'h0000_0202);
    tick();
    dm_ack = 1'b0;
    check("idle_ack_wb_valid", 32'(wb_valid), 32'd0);
    check("idle_ack_dm_req",   32'(dm_req),   32'd0);

    // SB replication
    issue(4'b0110, 5'd1, 1'b0, 32'h0000_0003, 32'h1234_56A5);
    check("sb_dm_sel",   32'(dm_sel), 32'b1000);
    check("sb_dm_wdata", dm_wdata,    32'hA5A5_A5A5);
    ack_now(32'd0);

    // Sign/zero extension on halfword and byte loads
    issue(4'b0011, 5'd4, 1'b1, 32'h0000_0012, 32'd0);
    check("lh_dm_sel", 32'(dm_sel), 32'b1100);
    ack_now(32'h8001_0000);
    check("lh_wdata_o", wdata_o, 32'hFFFF_8001);
    issue(4'b0010, 5'd4, 1'b1, 32'h0000_0021, 32'd0);
    check("lbu_dm_sel", 32'(dm_sel), 32'b0010);
    ack_now(32'h0000_F100);
    check("lbu_wdata_o", wdata_o, 32'h0000_00F1);
    issue(4'b0100, 5'd4, 1'b1, 32'h0000_0001, 32'd0);
    check("lhu_mis_dm_sel", 32'(dm_sel), 32'b0011);
    ack_now(32'h1234_ABCD);
    check("lhu_wdata_o", wdata_o, 32'h0000_ABCD);

    // Misaligned LW without alignment checking
    issue(4'b0101, 5'd6, 1'b1, 32'h0000_0101, 32'd0);
    check("lw_mis_dm_addr",   dm_addr,         32'h0000_0100);
    check("lw_mis_dm_sel",    32'(dm_sel),     32'b1111);
    check("lw_mis_align_exc", 32'(align_exc),  32'd0);
    ack_now(32'hDEAD_BEEF);
    check("lw_mis_wdata_o", wdata_o, 32'hDEAD_BEEF);

    // LW timeout: dm_req held exactly 16 cycles, then bus_err + wb_valid
    issue(4'b0101, 5'd8, 1'b1, 32'h0000_0400, 32'd0);
    req_cycles = 0; saw_err = 1'b0; wbv_at_err = 1'b0; wreg_at_err = 1'b1;
    for (int i = 0; i < 40 && !saw_err; i++) begin
      if (dm_req) req_cycles++;
      if (bus_err) begin
        saw_err = 1'b1; wbv_at_err = wb_valid; wreg_at_err = wreg_o;
      end else begin
        tick();
      end
    end
    check("to_seen",       32'(saw_err),     32'd1);
    check("to_req_cycles", 32'(req_cycles),  32'd16);
    check("to_wb_valid",   32'(wbv_at_err),  32'd1);
    check("to_wreg_o",     32'(wreg_at_err), 32'd0);
    tick();
    check("to_err_pulse", 32'(bus_err), 32'd0);

    // Ack in the timeout cycle wins
    issue(4'b0101, 5'd2, 1'b1, 32'h0000_0800, 32'd0);
    for (int i = 0; i < 15; i++) tick();
    check("edge_dm_req", 32'(dm_req), 32'd1);
    ack_now(32'hCAFE_F00D);
    check("edge_bus_err",  32'(bus_err),  32'd0);
    check("edge_wb_valid", 32'(wb_valid), 32'd1);
    check("edge_wdata_o",  wdata_o,       32'hCAFE_F00D);
    check("edge_wreg_o",   32'(wreg_o),   32'd1);

    // Reset during ACCESS; late ack ignored
    issue(4'b0101, 5'd11, 1'b1, 32'h0000_0500, 32'd0);
    check("rstacc_dm_req", 32'(dm_req), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("rstacc_async_dm_req", 32'(dm_req),    32'd0);
    check("rstacc_async_stall",  32'(stall_req), 32'd0);
    check("rstacc_async_wdata",  wdata_o,        32'd0);
    tick();
    rst = 1'b1;
    ack_now(32'h7777_7777);
    check("rstacc_wb_valid", 32'(wb_valid), 32'd0);
    check("rstacc_wdata_o",  wdata_o,       32'd0);
    check("rstacc_dm_req",   32'(dm_req),   32'd0);
    check("rstacc_ex_ready", 32'(ex_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 5, destination register address width.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 16, maximum cycles to wait for dm_ack (legal range 2..255).
REQ-003 SHALL have ports, in this order:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-low.
- ex_valid  in  1  EX result present.
- ex_ready  out  1  stage accepts EX result this cycle.
- ex_wd  in  REG_ADDR_W  destination register.
- ex_wreg  in  1  register write enable.
- ex_wdata  in  32  ALU result, also the memory address.
- ex_memop  in  4  0000 none, 0001 LB, 0010 LBU, 0011 LH, 0100 LHU, 0101 LW, 0110 SB, 0111 SH, 1000 SW; other codes act as none.
- ex_sdata  in  32  store data.
- dm_req  out  1  data-memory request.
- dm_we  out  1  write strobe.
- dm_addr  out  32  word address, bits [1:0] forced to 0.
- dm_sel  out  4  byte-lane enables, bit n = bits [8n+7:8n].
- dm_wdata  out  32  write data.
- dm_ack  in  1  request complete; dm_rdata valid in the same cycle.
- dm_rdata  in  32  read data.
- wb_valid  out  1  one-cycle pulse: result valid toward WB.
- wd_o  out  REG_ADDR_W; wreg_o  out  1; wdata_o  out  32: write-back triple.
- stall_req  out  1  pipeline stall request.
- bus_err  out  1  one-cycle timeout pulse.
- align_exc  out  1  one-cycle misalignment pulse (tied 0 without MEM_ALIGN_CHECK_EN).

Function
REQ-004 SHALL implement states IDLE and ACCESS; ex_ready = 1 only in IDLE; stall_req = 1 only in ACCESS.
REQ-005 In IDLE with ex_valid and a none memop, the stage SHALL register wd/wreg/wdata and assert wb_valid the next cycle (latency 1), staying in IDLE.
REQ-006 In IDLE with ex_valid and a load or store memop, the stage SHALL capture all inputs and enter ACCESS; dm_req SHALL be 1 from the next cycle.
REQ-007 In ACCESS, dm_req, dm_we, dm_addr, dm_sel and dm_wdata SHALL hold stable until dm_ack or timeout.
REQ-008 Lane selection (little-endian, a = address[1:0]): byte: dm_sel = 0001 << a; half: a[1]=0 gives 0011, a[1]=1 gives 1100; word: 1111.
REQ-009 Store data SHALL be replicated: SB gives {4{byte}}, SH gives {2{half}}, SW passes through unchanged.
REQ-010 Load result SHALL extract the selected lane, sign-extend for LB/LH and zero-extend for LBU/LHU.
REQ-011 On dm_ack in ACCESS, the stage SHALL register the result, pulse wb_valid the next cycle, drop dm_req, and return to IDLE.
- Load: wdata_o = formatted data, wreg_o = captured wreg.
- Store: wdata_o = captured ex_wdata, wreg_o = 0.
REQ-012 A 8-bit counter SHALL clear on ACCESS entry and increment each ACCESS cycle without ack; reaching ACK_TIMEOUT SHALL cause:
- dm_req dropped, bus_err and wb_valid pulsed, wreg_o = 0;
- return to IDLE.
REQ-013 dm_ack in the same cycle the timeout is reached SHALL win: normal completion, no bus_err.
REQ-014 dm_ack while in IDLE SHALL be ignored.
REQ-015 wd_o, wreg_o and wdata_o SHALL hold their last values between wb_valid pulses.

Reset
REQ-016 rst low SHALL asynchronously force:
- state IDLE, counter 0;
- all dm_* outputs 0;
- wb_valid, wreg_o, bus_err, align_exc and stall_req 0;
- wd_o 0, wdata_o 0x00000000.
REQ-017 Reset in ACCESS SHALL abandon the transfer with no wb_valid; a dm_ack arriving after release SHALL be ignored.

Configuration
REQ-018 Macro MEM_ALIGN_CHECK_EN defined: a halfword access with a[0]=1, or a word access with a≠00, SHALL skip ACCESS, issue no dm_req, and pulse align_exc and wb_valid with wreg_o = 0 one cycle later.
REQ-019 Macro undefined: misaligned low address bits SHALL be ignored (halfword uses a[1], word uses a = 00), and align_exc SHALL be constant 0.

Verification
REQ-020 Passthrough: memop 0000, ex_wd = 3, ex_wdata = 0x12345678 -> next cycle wb_valid = 1, wd_o = 3, wdata_o = 0x12345678, no dm_req.
REQ-021 LB at address 0x103, ack after 3 cycles with rdata 0x80FFFFFF -> dm_sel = 1000, stall_req high 3 cycles, wdata_o = 0xFFFFFF80.
REQ-022 SH at address 0x202 with sdata 0x0000BEEF -> dm_we = 1, dm_sel = 1100, dm_wdata = 0xBEEFBEEF, wreg_o = 0.
REQ-023 LW with no ack, ACK_TIMEOUT = 16 -> dm_req high exactly 16 cycles, then bus_err and wb_valid for one cycle.
REQ-024 rst low during ACCESS, then ack after release -> all outputs 0, no wb_valid.
REQ-025 With MEM_ALIGN_CHECK_EN, LW at 0x101 -> align_exc = 1, no dm_req; without the macro -> dm_addr = 0x100, dm_sel = 1111.
